// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive/transmit paths.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} t_rx_state;

  localparam int C_OVERSAMPLE = 16;

  // Rounded clock-per-oversample-tick divider, never below 1.
  function automatic int f_div(input int clk_hz, input int baud);
    int div;
    div = (clk_hz + baud * (C_OVERSAMPLE / 2)) / (baud * C_OVERSAMPLE);
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO; push while full is accepted only
// together with a pop. p_DEPTH must be a power of two.
module fifo_sync #(
  parameter int p_WIDTH = 8,
  parameter int p_DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [p_WIDTH-1:0]         data_i,
  input  logic                       pop_i,
  output logic [p_WIDTH-1:0]         data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(p_DEPTH):0]   level_o
);

  localparam int C_AW = $clog2(p_DEPTH);
  localparam int C_LW = C_AW + 1;

  logic [p_WIDTH-1:0] mem_q [p_DEPTH];
  logic [C_AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [C_AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [C_LW-1:0]    level_q, level_d;
  logic               wr_en_s;
  logic               rd_en_s;

  assign full_o  = (level_q == C_LW'(p_DEPTH));
  assign empty_o = (level_q == '0);
  assign wr_en_s = push_i && (!full_o || pop_i);
  assign rd_en_s = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, rd_en_s})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is cleared so the head byte reads as zero out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < p_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, 16x oversampling) feeding a FWFT byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames with an o_parity_err output.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int p_CLK_HZ     = 50000000,
  parameter int p_BAUD       = 115200,
  parameter int p_FIFO_DEPTH = 16
) (
  input  logic                            i_clk,
  input  logic                            i_arst,
  input  logic                            i_uart_rxd,
  output logic [7:0]                      ov_data,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic                            o_frame_err,
  output logic                            o_overflow,
`ifdef UART_RX_PARITY_EN
  output logic                            o_parity_err,
`endif
  output logic [$clog2(p_FIFO_DEPTH):0]   ov_level
);

  localparam int C_DIV   = f_div(p_CLK_HZ, p_BAUD);
  localparam int C_DIV_W = (C_DIV > 1) ? $clog2(C_DIV) : 1;
  localparam int C_SW    = $clog2(C_OVERSAMPLE);
  localparam logic [C_SW-1:0] C_MID  = C_SW'(C_OVERSAMPLE / 2 - 1);
  localparam logic [C_SW-1:0] C_LAST = C_SW'(C_OVERSAMPLE - 1);

  logic               sync1_q, sync2_q;
  logic               rxd_s;
  logic [C_DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic               tick_s;
  logic               start_s;
  t_rx_state          state_q;
  logic [C_SW-1:0]    sample_cnt_q;
  logic [2:0]         bit_idx_q;
  logic [7:0]         shift_q;
  logic               frame_err_q;
  logic               overflow_q;
  logic               parity_ok_s;
  logic               push_s;
  logic               full_s;
  logic               empty_s;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_uart_rxd;
      sync2_q <= sync1_q;
    end
  end

  assign rxd_s   = sync2_q;
  assign tick_s  = (div_cnt_q == C_DIV_W'(C_DIV - 1));
  assign start_s = (state_q == IDLE) && !rxd_s;

  // Oversample tick divider, re-phased on the start edge.
  always_comb begin
    if (start_s || tick_s) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  // Divider register.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad_q;
  logic par_err_q;
  assign parity_ok_s  = !par_bad_q;
  assign o_parity_err = par_err_q;
`else
  assign parity_ok_s = 1'b1;
`endif

  // Sample counter wraps every C_OVERSAMPLE ticks, so the last count is mid-bit.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      par_err_q    <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            state_q      <= START;
            sample_cnt_q <= '0;
          end
        end
        START: begin
          if (tick_s) begin
            if (sample_cnt_q == C_MID) begin
              sample_cnt_q <= '0;
              bit_idx_q    <= '0;
              state_q      <= rxd_s ? IDLE : DATA;
            end else begin
              sample_cnt_q <= sample_cnt_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick_s) begin
            sample_cnt_q <= sample_cnt_q + 1'b1;
            if (sample_cnt_q == C_LAST) begin
              shift_q   <= {rxd_s, shift_q[7:1]};
              bit_idx_q <= bit_idx_q + 1'b1;
              if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_s) begin
            sample_cnt_q <= sample_cnt_q + 1'b1;
            if (sample_cnt_q == C_LAST) begin
              par_bad_q <= ^{shift_q, rxd_s};
              par_err_q <= ^{shift_q, rxd_s};
              state_q   <= STOP;
            end
          end
        end
`endif
        STOP: begin
          if (tick_s) begin
            sample_cnt_q <= sample_cnt_q + 1'b1;
            if (sample_cnt_q == C_LAST) begin
              if (rxd_s) begin
                state_q <= IDLE;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= BREAK;
              end
            end
          end
        end
        BREAK: begin
          if (rxd_s) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign push_s = (state_q == STOP) && tick_s && (sample_cnt_q == C_LAST)
                  && rxd_s && parity_ok_s;

  // A full FIFO still takes the byte when the consumer pops in the same cycle.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= push_s && full_s && !i_ready;
    end
  end

  fifo_sync #(
    .p_WIDTH (8),
    .p_DEPTH (p_FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_arst),
    .push_i  (push_s),
    .data_i  (shift_q),
    .pop_i   (i_ready),
    .data_o  (ov_data),
    .full_o  (full_s),
    .empty_o (empty_s),
    .level_o (ov_level)
  );

  assign o_valid     = !empty_s;
  assign o_frame_err = frame_err_q;
  assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: serial frames are driven on the pin and
// the received stream is compared against a queue of bytes the line should yield.
module tb_uart_rx_fifo;

  localparam int CLK_HZ = 1843200;
  localparam int BAUD   = 115200;
  localparam int DEPTH  = 4;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Negedges from start-bit drive until the negedge just before the push edge.
  localparam int PUSH_NEG = 16 * (FRAME_BITS - 1) + 10;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       rxd = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       ovf;
  logic [2:0] level;
`ifdef UART_RX_PARITY_EN
  logic       par_err;
`endif

  int vec = 0;
  int mis = 0;
  int fe_cnt = 0;
  int ovf_cnt = 0;
  int pe_cnt = 0;
  int rx_cnt = 0;
  int valid_cycles = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .p_CLK_HZ     (CLK_HZ),
    .p_BAUD       (BAUD),
    .p_FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk        (clk),
    .i_arst       (arst),
    .i_uart_rxd   (rxd),
    .ov_data      (data),
    .o_valid      (valid),
    .i_ready      (ready),
    .o_frame_err  (frame_err),
    .o_overflow   (ovf),
`ifdef UART_RX_PARITY_EN
    .o_parity_err (par_err),
`endif
    .ov_level     (level)
  );

  // Observe pulses and every accepted byte.
  always @(negedge clk) begin
    if (!arst) begin
      if (frame_err) fe_cnt++;
      if (ovf) ovf_cnt++;
`ifdef UART_RX_PARITY_EN
      if (par_err) pe_cnt++;
`endif
      if (valid) valid_cycles++;
      if (valid && ready) begin
        vec++;
        rx_cnt++;
        if (exp_q.size() == 0) begin
          mis++;
          $display("FAIL rx_unexpected: got byte %02h, required no byte", data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (data !== e) begin
            mis++;
            $display("FAIL rx_data: got %02h, required %02h", data, e);
          end
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`else
    if (par_flip) rxd = 1'b1;
`endif
    drive_bit(stop_bit);
  endtask

  task automatic drain(input string name);
    ready = 1'b1;
    for (int i = 0; i < 64 && valid; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    vec++;
    if (valid !== 1'b0 || exp_q.size() != 0 || level !== 3'd0) begin
      mis++;
      $display("FAIL %s_drain: valid=%0b level=%0d pending=%0d, required 0/0/0",
               name, valid, level, exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vec++;
    if ({data, valid, frame_err, ovf, level} !== 14'd0) begin
      mis++;
      $display("FAIL reset_outputs: data=%02h valid=%0b fe=%0b ovf=%0b level=%0d, required all 0",
               data, valid, frame_err, ovf, level);
    end
    arst = 1'b0;
    repeat (3) @(negedge clk);
    vec++;
    if (valid !== 1'b0 || level !== 3'd0) begin
      mis++;
      $display("FAIL reset_release: valid=%0b level=%0d, required 0/0", valid, level);
    end
  endtask

  task automatic test_single();
    int rx0, vc0, fe0;
    ready = 1'b1;
    rx0 = rx_cnt; vc0 = valid_cycles; fe0 = fe_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    vec++;
    if (rx_cnt - rx0 != 1 || valid_cycles - vc0 != 1 || fe_cnt != fe0 || ovf_cnt != 0) begin
      mis++;
      $display("FAIL single_frame: rx=%0d valid_cycles=%0d fe=%0d ovf=%0d, required 1/1/0/0",
               rx_cnt - rx0, valid_cycles - vc0, fe_cnt - fe0, ovf_cnt);
    end
  endtask

  task automatic test_glitch();
    int rx0, fe0;
    rx0 = rx_cnt; fe0 = fe_cnt;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    vec++;
    if (rx_cnt != rx0 || fe_cnt != fe0 || level !== 3'd0) begin
      mis++;
      $display("FAIL glitch_reject: rx=%0d fe=%0d level=%0d, required 0/0/0",
               rx_cnt - rx0, fe_cnt - fe0, level);
    end
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    vec++;
    if (rx_cnt - rx0 != 1) begin
      mis++;
      $display("FAIL glitch_recover: rx=%0d, required 1", rx_cnt - rx0);
    end
  endtask

  task automatic test_frame_err();
    int rx0, fe0;
    rx0 = rx_cnt; fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (60) @(negedge clk);
    vec++;
    if (level !== 3'd0) begin
      mis++;
      $display("FAIL frame_err_level: level=%0d, required 0", level);
    end
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    vec++;
    if (fe_cnt - fe0 != 1 || rx_cnt != rx0) begin
      mis++;
      $display("FAIL frame_err_pulse: pulses=%0d rx=%0d, required 1/0", fe_cnt - fe0, rx_cnt - rx0);
    end
  endtask

  task automatic test_overflow();
    int ov0;
    ready = 1'b0;
    ov0 = ovf_cnt;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, 1'b0);
    end
    vec++;
    if (level !== 3'd4 || ovf_cnt != ov0) begin
      mis++;
      $display("FAIL overflow_fill: level=%0d ovf=%0d, required 4/0", level, ovf_cnt - ov0);
    end
    send_frame(8'h05, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    vec++;
    if (level !== 3'd4 || ovf_cnt - ov0 != 1) begin
      mis++;
      $display("FAIL overflow_drop: level=%0d ovf=%0d, required 4/1", level, ovf_cnt - ov0);
    end
    drain("overflow");
  endtask

  task automatic test_back_to_back();
    int ov0;
    logic [7:0] b;
    ready = 1'b0;
    ov0 = ovf_cnt;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b1, 1'b0);
    end
    b = 8'($urandom);
    exp_q.push_back(b);
    fork
      send_frame(b, 1'b1, 1'b0);
      begin
        repeat (PUSH_NEG) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        vec++;
        if (level !== 3'd4) begin
          mis++;
          $display("FAIL full_push_pop_level: level=%0d, required 4", level);
        end
        ready = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    vec++;
    if (ovf_cnt != ov0 || level !== 3'd4) begin
      mis++;
      $display("FAIL full_push_pop_ovf: ovf=%0d level=%0d, required 0/4", ovf_cnt - ov0, level);
    end
    drain("back_to_back");
  endtask

  task automatic test_reset_mid();
    int rx0;
    ready = 1'b0;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b0);
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        repeat (60) @(negedge clk);
        arst = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clk);
        vec++;
        if (valid !== 1'b0 || level !== 3'd0 || data !== 8'h00) begin
          mis++;
          $display("FAIL reset_mid_clear: valid=%0b level=%0d data=%02h, required 0/0/00",
                   valid, level, data);
        end
        arst = 1'b0;
      end
    join
    ready = 1'b1;
    rx0 = rx_cnt;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    vec++;
    if (rx_cnt - rx0 != 1 || exp_q.size() != 0) begin
      mis++;
      $display("FAIL reset_mid_rx: rx=%0d pending=%0d, required 1/0", rx_cnt - rx0, exp_q.size());
    end
  endtask

  task automatic test_parity();
`ifdef UART_RX_PARITY_EN
    int rx0, pe0, fe0;
    rx0 = rx_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    ready = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b1);
    repeat (8) @(negedge clk);
    vec++;
    if (pe_cnt - pe0 != 1 || rx_cnt != rx0 || fe_cnt != fe0 || level !== 3'd0) begin
      mis++;
      $display("FAIL parity_err: pulses=%0d rx=%0d fe=%0d level=%0d, required 1/0/0/0",
               pe_cnt - pe0, rx_cnt - rx0, fe_cnt - fe0, level);
    end
`endif
  endtask

  task automatic test_random();
    int rx0, fe0, exp_rx, exp_fe;
    logic [7:0] b;
    logic bad;
    rx0 = rx_cnt; fe0 = fe_cnt; exp_rx = 0; exp_fe = 0;
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      if (bad) begin
        exp_fe++;
      end else begin
        exp_rx++;
        exp_q.push_back(b);
      end
      send_frame(b, !bad, 1'b0);
      if (bad) drive_bit(1'b1);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    vec++;
    if (rx_cnt - rx0 != exp_rx || fe_cnt - fe0 != exp_fe || exp_q.size() != 0) begin
      mis++;
      $display("FAIL random_stream: rx=%0d fe=%0d pending=%0d, required %0d/%0d/0",
               rx_cnt - rx0, fe_cnt - fe0, exp_q.size(), exp_rx, exp_fe);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_parity();
    test_random();
    vec++;
    if (pe_cnt != 0 && FRAME_BITS == 10) begin
      mis++;
      $display("FAIL parity_absent: pulses=%0d, required 0", pe_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
